data_seg_ctrl: RTL

//  Parametrised data-memory segment for the RISCV core. It replaces the plain word-addressed RAM hookup.
//  - Takes byte/half/word load-store requests over a valid/ready handshake.
//  - Generates byte lanes and write data internally; sign/zero-extends load data.
//  - Splits word-crossing misaligned accesses into two RAM cycles.
//  - Keeps the independent debug port B.
//  - Sits between the MEM stage and the dual-port data BRAM.

---
 rtl/data_seg_pkg.sv | 57 +++++
 rtl/data_seg_bram.sv | 31 +++
 rtl/data_seg_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/data_seg_pkg.sv
// Shared encodings and lane helpers for the data-memory segment.
// Sizes follow RISC-V funct3 for loads and stores.
package data_seg_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        RESP
    } state_t;

    // Eight lanes: [3:0] address word idx, [7:4] word idx+1.
    function automatic logic [7:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [7:0] base;
        unique case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [31:0] raw,
        input logic [2:0]  size
    );
        logic [31:0] r;
        r = raw;
        case (size)
            SZ_B:    r = {{24{raw[7]}}, raw[7:0]};
            SZ_H:    r = {{16{raw[15]}}, raw[15:0]};
            SZ_BU:   r = {24'h0, raw[7:0]};
            SZ_HU:   r = {16'h0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    function automatic logic size_legal(
        input logic       we,
        input logic [2:0] size
    );
        if (we)
            return size[1:0] != 2'b11;
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

endpackage

// File: rtl/data_seg_bram.sv
// True dual-port byte-write RAM, read-first, synchronous read.
// Port A owns any lane both ports write in the same cycle.
module data_seg_bram #(
    parameter int DEPTH_WORDS = 4096,
    localparam int IW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    a_we,
    input  logic [IW-1:0] a_idx,
    input  logic [31:0]   a_wdata,
    output logic [31:0]   a_rdata,
    input  logic [3:0]    b_we,
    input  logic [IW-1:0] b_idx,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        a_rdata <= mem[a_idx];
        b_rdata <= mem[b_idx];
        for (int i = 0; i < 4; i++) begin
            if (b_we[i] && !(a_we[i] && (a_idx == b_idx)))
                mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
            if (a_we[i])
                mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_seg_ctrl.sv
// Load/store front end for the data BRAM: lanes, extension,
// and two-cycle splitting of word-crossing accesses.
import data_seg_pkg::*;

module data_seg_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DEPTH_WORDS    = 4096,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_split,
    input  logic [3:0]        dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata
);

    localparam int IW = $clog2(DEPTH_WORDS);

    state_t state, state_nx;

    logic          accept;
    logic [1:0]    off;
    logic [IW-1:0] idx;
    logic [7:0]    mask;
    logic [63:0]   wide;
    logic          misal;
    logic          err;
    logic          split;

    logic          r_we;
    logic [2:0]    r_size;
    logic [1:0]    r_off;
    logic          r_err;
    logic          r_split;
    logic [IW-1:0] hi_idx;
    logic [3:0]    hi_be;
    logic [31:0]   hi_wd;
    logic [31:0]   lo_word;

    logic [3:0]    a_we;
    logic [IW-1:0] a_idx;
    logic [31:0]   a_wdata;
    logic [31:0]   a_rdata;
    logic [63:0]   raw64;
    logic [63:0]   shifted;
    logic          unused_bits;

    assign req_ready = (state != SECOND);
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[1:0];
    assign idx       = req_addr[2 +: IW];
    assign mask      = lane_mask(req_size[1:0], off);
    assign misal     = |mask[7:4];
    assign err       = !size_legal(req_we, req_size) ||
                       (misal && (ALLOW_MISALIGN == 0));
    assign split     = misal && !err;
    assign wide      = {32'h0, req_wdata} << {off, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, RESP: begin
                if (accept)
                    state_nx = split ? SECOND : RESP;
                else
                    state_nx = IDLE;
            end
            SECOND:  state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_off   <= 2'b00;
            r_err   <= 1'b0;
            r_split <= 1'b0;
            hi_idx  <= '0;
            hi_be   <= 4'h0;
            hi_wd   <= 32'h0;
            lo_word <= 32'h0;
        end else begin
            if (accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_off   <= off;
                r_err   <= err;
                r_split <= split;
                hi_idx  <= idx + IW'(1);
                hi_be   <= (req_we && split) ? mask[7:4] : 4'h0;
                hi_wd   <= wide[63:32];
            end
            // First-half word arrives while the second half is issued.
            if (state == SECOND)
                lo_word <= a_rdata;
        end
    end

    always_comb begin
        a_idx   = idx;
        a_we    = 4'h0;
        a_wdata = wide[31:0];
        if (state == SECOND) begin
            a_idx   = hi_idx;
            a_we    = hi_be;
            a_wdata = hi_wd;
        end else if (accept && req_we && !err) begin
            a_we = mask[3:0];
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_split = resp_valid && r_split;
    assign raw64      = r_split ? {a_rdata, lo_word} : {32'h0, a_rdata};
    assign shifted    = raw64 >> {r_off, 3'b000};
    assign resp_rdata = (resp_valid && !r_we && !r_err) ?
                        load_extend(shifted[31:0], r_size) : 32'h0;

    data_seg_bram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bram (
        .clk     (clk),
        .a_we    (a_we),
        .a_idx   (a_idx),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_we    (dbg_we),
        .b_idx   (dbg_addr[2 +: IW]),
        .b_wdata (dbg_wdata),
        .b_rdata (dbg_rdata)
    );

    assign unused_bits = ^{req_addr[ADDR_W-1:2+IW], dbg_addr[ADDR_W-1:2+IW],
                           dbg_addr[1:0], shifted[63:32]};

endmodule
